hram_traffic_checker: RTL and testbench
=======================================

Name: hram_traffic_checker

Overview:
- Avalon-MM master that exercises the HyperRAM controller inside top_level: writes a deterministic pattern over an address range, reads it back, compares, reports pass/fail and error statistics.
- Sits directly upstream of the controller's Avalon-MM slave and is instantiated in the simulation bench and the on-board self-test.
- Runs on the clock and reset from clk_rst_generator.

Parameters:
- ADDR_W, 22, word address width of the master port (16-bit words).
- SEED, 16'hA5C3, XOR constant applied to the pattern.
- MAX_OUTSTANDING, 4, maximum read commands issued but not yet returned (1..15).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- base_address  in  ADDR_W  first word address; sampled on an accepted start.
- word_count  in  ADDR_W  number of words to test; sampled on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of a test.
- pass  out  1  valid from done until the next start; 1 when error_count==0.
- error_count  out  16  number of mismatched words; saturates at 16'hFFFF.
- first_err_addr  out  ADDR_W  address of the first mismatch; 0 if there is none.
- avm_address  out  ADDR_W  word address.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_writedata  out  16  write data.
- avm_byteenable  out  2  constant 2'b11 while write is asserted, else 2'b00.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  16  read data.
- avm_readdatavalid  in  1  read data qualifier.

Behaviour:
- Reset: state=IDLE, all outputs 0. This includes avm_read, avm_write, avm_address, busy, done, pass, error_count and first_err_addr.
- Reset asserted mid-test: the master drops read/write on the next edge. In-flight read returns are ignored until the next start.
- Pattern: expected(a) = a[15:0] ^ SEED, where a is the word address.
- FSM IDLE -> WRITE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE: on start, latch base and count, clear error_count, first_err_addr and pass. Go to WRITE, or to DONE if word_count==0.
- WRITE:
  - avm_write=1, avm_address=base+wr_idx, avm_writedata=expected(avm_address).
  - Address, data and write are held stable while avm_waitrequest=1.
  - The transfer completes on a cycle with write=1 and waitrequest=0; wr_idx then increments.
  - After the last word, go to READ with write deasserted for at least 1 cycle.
- READ:
  - avm_read=1 while rd_issue_idx<count and outstanding<MAX_OUTSTANDING. Otherwise read=0.
  - Address is held while waitrequest=1. An issue completes on read=1 and waitrequest=0.
  - When all reads are issued, go to DRAIN.
- Outstanding counter:
  - +1 on each completed issue, -1 on each readdatavalid.
  - Both events in the same cycle leave it unchanged.
  - It never exceeds MAX_OUTSTANDING.
- Compare:
  - Each readdatavalid compares avm_readdata against expected(base+rd_ret_idx), then rd_ret_idx increments. Returns are in order.
  - On a mismatch, error_count increments, saturating.
  - On the first mismatch, first_err_addr = base+rd_ret_idx.
  - readdatavalid in IDLE, WRITE or DONE is ignored.
- DRAIN: wait until rd_ret_idx==count, then go to DONE.
- DONE: done=1 for exactly 1 cycle, pass=(error_count==0) (including the final-cycle compare), busy=0 from the next cycle, return to IDLE.
- word_count==0: done pulses 2 cycles after start, pass=1, no bus activity.
- Address arithmetic: wraps modulo 2^ADDR_W (base+idx beyond the top wraps to 0). The expected pattern uses the wrapped address.
- start while busy: ignored.
- Latency with waitrequest=0 and fixed read latency L:
  - count write cycles, then ceil-limited read issues.
  - done occurs no later than 2*count + L + 4 cycles after start when L < MAX_OUTSTANDING.

Test Plan:
- Reset, then start with base=0 and count=8 against the HyperRAM model. Required: 8 writes with data 16'hA5C3, 16'hA5C2, ... 16'hA5C4; 8 reads; done pulse; pass=1; error_count=0.
- Slave holds waitrequest=1 for 5 cycles on write #3. Required: address and data stable across the stall; no duplicate or skipped write; pass=1.
- Read latency of 10 cycles with MAX_OUTSTANDING=4. Required: avm_read never issues while 4 reads are outstanding; the counter never exceeds 4; done after all 8 returns.
- Fault-injecting slave flips bit 0 of readdata at addresses 0x005 and 0x007 (base=0, count=8). Required: error_count=2, first_err_addr=0x005, pass=0.
- Zero and wrap cases:
  - word_count=0 gives done 2 cycles after start, pass=1, no read/write.
  - base=2^ADDR_W-2 with count=4 gives addresses ...FE, ...FF, 0, 1.
- Assert reset during READ with 3 reads outstanding. Required: read/write/busy=0 next cycle; late readdatavalid leaves error_count=0; a subsequent start runs normally.

Source files
------------

// File: rtl/hram_traffic_checker.sv
// Avalon-MM traffic master for the HyperRAM controller: writes an address-derived
// pattern over a range, reads it back with bounded outstanding reads, and reports errors.
module hram_traffic_checker #(
  parameter int unsigned ADDR_W          = 22,
  parameter logic [15:0] SEED            = 16'hA5C3,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_address,
  input  logic [ADDR_W-1:0] word_count,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       error_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [15:0]       avm_writedata,
  output logic [1:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [15:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

  localparam logic [3:0]        MaxOut  = 4'(MAX_OUTSTANDING);
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, count_q, count_d;
  logic [ADDR_W-1:0] wr_idx_q, wr_idx_d, rd_iss_q, rd_iss_d, rd_ret_q, rd_ret_d;
  logic [ADDR_W-1:0] first_err_q, first_err_d;
  logic [3:0]        outstanding_q, outstanding_d;
  logic [15:0]       err_q, err_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;

  logic [ADDR_W-1:0] wr_addr, rd_addr, ret_addr;
  logic              start_ok, wr_fire, rd_fire, ret_fire, mismatch;

  function automatic logic [15:0] pattern(input logic [ADDR_W-1:0] a);
    return 16'(a) ^ SEED;
  endfunction

  // Address sums wrap naturally at ADDR_W bits.
  assign wr_addr  = base_q + wr_idx_q;
  assign rd_addr  = base_q + rd_iss_q;
  assign ret_addr = base_q + rd_ret_q;

  assign avm_write      = (state_q == StWrite);
  assign avm_read       = (state_q == StRead) && (rd_iss_q < count_q) &&
                          (outstanding_q < MaxOut);
  assign avm_address    = (state_q == StWrite) ? wr_addr :
                          (state_q == StRead)  ? rd_addr : '0;
  assign avm_writedata  = avm_write ? pattern(wr_addr) : 16'h0000;
  assign avm_byteenable = avm_write ? 2'b11 : 2'b00;

  assign start_ok = start && (state_q == StIdle) && !busy_q;
  assign wr_fire  = avm_write && !avm_waitrequest;
  assign rd_fire  = avm_read && !avm_waitrequest;
  // Returns only count while a read phase is live; stale returns after reset are dropped.
  assign ret_fire = avm_readdatavalid && ((state_q == StRead) || (state_q == StDrain));
  assign mismatch = ret_fire && (avm_readdata != pattern(ret_addr));

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign error_count    = err_q;
  assign first_err_addr = first_err_q;

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    count_d       = count_q;
    wr_idx_d      = wr_idx_q;
    rd_iss_d      = rd_iss_q;
    rd_ret_d      = rd_ret_q;
    first_err_d   = first_err_q;
    outstanding_d = outstanding_q;
    err_d         = err_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    pass_d        = pass_q;

    case ({rd_fire, ret_fire})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase

    if (ret_fire) begin
      rd_ret_d = rd_ret_q + AddrOne;
      if (mismatch) begin
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        if (err_q == 16'h0000) first_err_d = ret_addr;
      end
    end

    // busy covers the done cycle and drops right after it.
    if (done_q) busy_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          base_d        = base_address;
          count_d       = word_count;
          wr_idx_d      = '0;
          rd_iss_d      = '0;
          rd_ret_d      = '0;
          outstanding_d = '0;
          err_d         = 16'h0000;
          first_err_d   = '0;
          pass_d        = 1'b0;
          busy_d        = 1'b1;
          state_d       = (word_count == '0) ? StDone : StWrite;
        end
      end
      StWrite: begin
        if (wr_fire) begin
          wr_idx_d = wr_idx_q + AddrOne;
          if (wr_idx_q == count_q - AddrOne) state_d = StRead;
        end
      end
      StRead: begin
        if (rd_fire) begin
          rd_iss_d = rd_iss_q + AddrOne;
          if (rd_iss_q == count_q - AddrOne) state_d = StDrain;
        end
      end
      StDrain: begin
        if (rd_ret_q == count_q) state_d = StDone;
      end
      StDone: begin
        done_d  = 1'b1;
        pass_d  = (err_q == 16'h0000);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      base_q        <= '0;
      count_q       <= '0;
      wr_idx_q      <= '0;
      rd_iss_q      <= '0;
      rd_ret_q      <= '0;
      first_err_q   <= '0;
      outstanding_q <= '0;
      err_q         <= 16'h0000;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      count_q       <= count_d;
      wr_idx_q      <= wr_idx_d;
      rd_iss_q      <= rd_iss_d;
      rd_ret_q      <= rd_ret_d;
      first_err_q   <= first_err_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
    end
  end

endmodule

// File: tb/tb_hram_traffic_checker.sv
// Bench for hram_traffic_checker: memory slave with stall, latency and fault knobs,
// plus a transaction-level model checked on every cycle.
module tb_hram_traffic_checker;

  localparam int unsigned AW   = 22;
  localparam logic [15:0] SEED = 16'hA5C3;
  localparam int unsigned MAXO = 4;

  logic          clock;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_address;
  logic [AW-1:0] word_count;
  logic          busy;
  logic          done;
  logic          pass;
  logic [15:0]   error_count;
  logic [AW-1:0] first_err_addr;
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic          avm_write;
  logic [15:0]   avm_writedata;
  logic [1:0]    avm_byteenable;
  logic          avm_waitrequest;
  logic [15:0]   avm_readdata;
  logic          avm_readdatavalid;

  hram_traffic_checker #(
    .ADDR_W          (AW),
    .SEED            (SEED),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .base_address      (base_address),
    .word_count        (word_count),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .error_count       (error_count),
    .first_err_addr    (first_err_addr),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
  } ret_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Slave model
  logic [15:0]   mem [logic [AW-1:0]];
  ret_t          rq[$];
  int            lat       = 3;
  int            stall_idx = -1;
  int            stall_len = 0;
  int            stall_cnt = 0;
  bit            fault_en  = 0;
  bit            fault_all = 0;
  logic [AW-1:0] fault_a0  = '0;
  logic [AW-1:0] fault_a1  = '0;

  // Transaction-level model of the checker
  bit            m_active = 0;
  logic [AW-1:0] m_base   = '0;
  logic [AW-1:0] m_first  = '0;
  int            m_count, m_wr, m_iss, m_ret, m_err, m_start_cyc;
  int            outst     = 0;
  int            max_outst = 0;
  int            done_cnt  = 0;
  int            done_cyc  = 0;
  int            d0        = 0;
  bit            prev_done = 0;

  function automatic logic [15:0] pat(input logic [AW-1:0] a);
    return a[15:0] ^ SEED;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Per-cycle slave + compare process. DUT outputs depend only on its registers,
  // so slave inputs set here are exactly what the next rising edge sees.
  initial begin
    ret_t          r;
    logic [15:0]   d;
    logic [AW-1:0] ea;
    bit            got_ret;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(negedge clock);
      cyc++;
      avm_waitrequest = 1'b0;
      if (avm_write && m_wr == stall_idx && stall_cnt < stall_len) begin
        avm_waitrequest = 1'b1;
        stall_cnt++;
      end
      got_ret           = 0;
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        d = mem.exists(r.addr) ? mem[r.addr] : 16'h0000;
        if (fault_all || (fault_en && (r.addr == fault_a0 || r.addr == fault_a1))) d[0] = ~d[0];
        avm_readdatavalid = 1'b1;
        avm_readdata      = d;
        got_ret           = 1;
      end

      check("byteenable", 32'(avm_byteenable), avm_write ? 32'd3 : 32'd0);
      check("rd_wr_exclusive", 32'(avm_read && avm_write), 32'd0);
      check("busy", 32'(busy), 32'(m_active));
      if (!m_active) check("idle_bus", {30'd0, avm_read, avm_write}, 32'd0);

      if (avm_write) begin
        ea = m_base + AW'(m_wr);
        check("wr_in_range", 32'(m_wr < m_count), 32'd1);
        check("wr_addr", 32'(avm_address), 32'(ea));
        check("wr_data", 32'(avm_writedata), 32'(pat(ea)));
        if (!avm_waitrequest) begin
          mem[avm_address] = avm_writedata;
          m_wr++;
        end
      end
      if (avm_read) begin
        ea = m_base + AW'(m_iss);
        check("rd_in_range", 32'(m_iss < m_count), 32'd1);
        check("rd_outstanding", 32'(outst < MAXO), 32'd1);
        check("rd_addr", 32'(avm_address), 32'(ea));
      end

      if (got_ret && m_active) begin
        ea = m_base + AW'(m_ret);
        if (d != pat(ea)) begin
          m_err++;
          if (m_err == 1) m_first = ea;
        end
        m_ret++;
        outst--;
      end
      if (avm_read && !avm_waitrequest) begin
        rq.push_back('{due: cyc + lat, addr: avm_address});
        m_iss++;
        outst++;
      end
      if (outst > max_outst) max_outst = outst;

      if (done) begin
        check("done_single", 32'(prev_done), 32'd0);
        check("done_active", 32'(m_active), 32'd1);
        check("done_writes", m_wr, m_count);
        check("done_returns", m_ret, m_count);
        check("done_pass", 32'(pass), 32'(m_err == 0));
        check("done_err_count", 32'(error_count), m_err);
        check("done_first_err", 32'(first_err_addr), 32'(m_first));
        done_cnt++;
        done_cyc = cyc;
        m_active = 0;
      end
      prev_done = done;
    end
  end

  task automatic kick(input logic [AW-1:0] b, input int n);
    @(negedge clock);
    #1;
    base_address = b;
    word_count   = AW'(n);
    start        = 1'b1;
    m_base       = b;
    m_count      = n;
    m_wr         = 0;
    m_iss        = 0;
    m_ret        = 0;
    m_err        = 0;
    m_first      = '0;
    outst        = 0;
    max_outst    = 0;
    stall_cnt    = 0;
    m_active     = 1;
    m_start_cyc  = cyc;
    d0           = done_cnt;
    @(negedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int lat_cycles);
    lat_cycles = -1;
    for (int k = 0; k < limit; k++) begin
      if (done_cnt != d0) break;
      @(negedge clock);
      #1;
    end
    if (done_cnt != d0) begin
      lat_cycles = done_cyc - m_start_cyc;
    end else begin
      checks++;
      errors++;
      $display("FAIL done_timeout got no done expected done within %0d cycles", limit);
      m_active = 0;
    end
  endtask

  task automatic run(input logic [AW-1:0] b, input int n, output int lat_cycles);
    kick(b, n);
    wait_done(400, lat_cycles);
  endtask

  initial begin
    int l;
    reset        = 1'b1;
    start        = 1'b0;
    base_address = '0;
    word_count   = '0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(error_count), 32'd0);
    check("rst_first", 32'(first_err_addr), 32'd0);
    check("rst_bus", {30'd0, avm_read, avm_write}, 32'd0);
    check("rst_addr", 32'(avm_address), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Basic run, L=3: pattern literals and latency bound 2*8+3+4
    lat = 3;
    run('0, 8, l);
    check("t1_latency_ok", 32'(l >= 0 && l <= 23), 32'd1);
    check("t1_mem0", 32'(mem[22'h0]), 32'hA5C3);
    check("t1_mem1", 32'(mem[22'h1]), 32'hA5C2);
    check("t1_mem7", 32'(mem[22'h7]), 32'hA5C4);
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_err", 32'(error_count), 32'd0);

    // Five-cycle stall on write #3
    stall_idx = 3;
    stall_len = 5;
    run('0, 8, l);
    check("t2_stalled", stall_cnt, 5);
    check("t2_pass", 32'(pass), 32'd1);
    stall_idx = -1;
    stall_len = 0;

    // L=10 fills the outstanding window; a start while busy must be ignored
    lat = 10;
    kick('0, 8);
    repeat (20) @(negedge clock);
    #1;
    start        = 1'b1;
    base_address = 22'd100;
    word_count   = 22'd3;
    @(negedge clock);
    #1;
    start = 1'b0;
    wait_done(400, l);
    check("t3_max_outst", max_outst, 4);
    check("t3_pass", 32'(pass), 32'd1);

    // Bit-0 faults at 5 and 7
    lat      = 3;
    fault_en = 1;
    fault_a0 = 22'h5;
    fault_a1 = 22'h7;
    run('0, 8, l);
    check("t4_err", 32'(error_count), 32'd2);
    check("t4_first", 32'(first_err_addr), 32'h5);
    check("t4_pass", 32'(pass), 32'd0);
    fault_en = 0;

    // Zero-length test
    run('0, 0, l);
    check("t5_done_delay", l, 2);
    check("t5_pass", 32'(pass), 32'd1);

    // Wrap at the top of the address space
    mem.delete();
    run(22'h3FFFFE, 4, l);
    check("t6_mem_fe", 32'(mem[22'h3FFFFE]), 32'h5A3D);
    check("t6_mem_ff", 32'(mem[22'h3FFFFF]), 32'h5A3C);
    check("t6_mem_0", 32'(mem[22'h0]), 32'hA5C3);
    check("t6_mem_1", 32'(mem[22'h1]), 32'hA5C2);
    check("t6_pass", 32'(pass), 32'd1);

    // Reset in READ with 3 reads in flight; late (corrupted) returns must be ignored
    lat = 10;
    kick('0, 8);
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      #1;
      if (outst == 3) break;
    end
    check("t7_reached_3", outst, 3);
    reset     = 1'b1;
    m_active  = 0;
    outst     = 0;
    fault_all = 1;
    @(negedge clock);
    #1;
    check("t7_read_dropped", 32'(avm_read), 32'd0);
    check("t7_write_dropped", 32'(avm_write), 32'd0);
    check("t7_busy_dropped", 32'(busy), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (rq.size() == 0) break;
      @(negedge clock);
      #1;
    end
    check("t7_drained", rq.size(), 0);
    @(negedge clock);
    #1;
    check("t7_err_after", 32'(error_count), 32'd0);
    check("t7_first_after", 32'(first_err_addr), 32'd0);
    fault_all = 0;
    lat       = 3;
    run('0, 8, l);
    check("t7_rerun_pass", 32'(pass), 32'd1);
    check("t7_rerun_err", 32'(error_count), 32'd0);

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
